// File: rtl/word_narrower_16in_8out.sv
// rtl/word_narrower_16in_8out.sv - splits 16-bit words into a valid/ready byte stream
// One word per handshake, two bytes out (one when compact drops a zero high byte).
module word_narrower_16in_8out #(
  parameter logic LOW_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bit16_in,
  input  logic        in_valid,
  input  logic        compact,
  output logic        in_ready,
  output logic [7:0]  bit8_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] byte_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [15:0] count_q, count_d;
  logic        out_take;
  logic        in_take;
  logic        drop;

  assign out_valid  = (state_q != IDLE);
  assign out_take   = out_valid && out_ready;
  // Ready is held low during reset even though the state already reads IDLE.
  assign in_ready   = reset_n && ((state_q == IDLE) || (out_take && last_q));
  assign in_take    = in_valid && in_ready;
  assign drop       = compact && (bit16_in[15:8] == 8'h00);
  assign bit8_out   = byte_q;
  assign out_last   = last_q;
  assign busy       = (state_q != IDLE);
  assign byte_count = count_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    last_d  = last_q;
    count_d = count_q;
    if (out_take) begin
      count_d = count_q + 16'd1;
      if (last_q) begin
        state_d = IDLE;
        byte_d  = 8'h00;
        last_d  = 1'b0;
      end else begin
        state_d = SECOND;
        byte_d  = LOW_FIRST ? word_q[15:8] : word_q[7:0];
        last_d  = 1'b1;
      end
    end
    // A new word overrides the return to IDLE so back-to-back words have no bubble.
    if (in_take) begin
      state_d = FIRST;
      word_d  = bit16_in;
      byte_d  = (drop || LOW_FIRST) ? bit16_in[7:0] : bit16_in[15:8];
      last_d  = drop;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= 16'h0000;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/word_narrower_16in_8out.md
# word_narrower_16in_8out

Streaming narrower that splits 16-bit words from the datapath into an 8-bit byte stream for the byte-wide memory/IO port, the counterpart of the 8-to-16 zero extender on the load path. It accepts one word per valid/ready handshake and emits two bytes, or one byte in compact mode when the high byte is zero. Both sides use valid/ready flow control. A running byte counter supports debug and bench checking.

## Interface
- LOW_FIRST, 1, 1: low byte [7:0] emitted first; 0: high byte [15:8] first
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- bit16_in  input  16  word to narrow
- in_valid  input  1  bit16_in and compact are valid
- compact  input  1  sampled with the word; 1 means drop the high byte when it is 8'h00
- in_ready  output  1  block can accept a word this cycle
- bit8_out  output  8  current byte
- out_valid  output  1  bit8_out is valid
- out_ready  input  1  consumer accepts bit8_out this cycle
- out_last  output  1  bit8_out is the final byte of its word
- busy  output  1  a word is held (state != IDLE)
- byte_count  output  16  bytes accepted by consumer since reset, wraps

## Operation
- States:
  - IDLE: no word held.
  - FIRST: presenting the first byte.
  - SECOND: presenting the second byte.
- Word accept happens when in_valid && in_ready at a rising edge:
  - bit16_in is latched into the word register, and the compact-drop decision is latched.
  - drop = compact && (bit16_in[15:8] == 8'h00).
  - Next state is FIRST.
- FIRST:
  - drop = 1: bit8_out = word[7:0] and out_last = 1, regardless of LOW_FIRST.
  - drop = 0: bit8_out is the low byte if LOW_FIRST = 1, otherwise the high byte; out_last = 0.
  - On out_ready: drop → IDLE (or FIRST if a new word is accepted the same cycle); otherwise → SECOND.
- SECOND:
  - bit8_out is the other byte; out_last = 1.
  - On out_ready → IDLE, or FIRST if a new word is accepted the same cycle.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is a combinational path from out_ready.
- out_valid = 1 in FIRST and SECOND, 0 in IDLE.
- bit8_out is registered and driven from the held word, so it is independent of bit16_in after the word is accepted.
- Simultaneous last-byte acceptance and new-word acceptance: the new word loads and the block enters FIRST with no idle cycle. No word is lost or duplicated.
- While out_valid && !out_ready: bit8_out, out_last and state hold. bit16_in changes are ignored.
- byte_count:
  - Increments by 1 on every out_valid && out_ready.
  - Wraps 16'hFFFF → 16'h0000 with no flag.
- compact is only sampled at word acceptance. Changing it mid-word has no effect.

## Timing
- Reset (reset_n low, asynchronous) forces:
  - state IDLE
  - out_valid 0, out_last 0, bit8_out 8'h00
  - byte_count 16'h0000, busy 0
  - in_ready 0 while reset_n is low, 1 from the first cycle after release
- Reset mid-word discards the held word. No partial byte is presented after release.
- Latency: a word accepted at edge N presents its first byte (out_valid = 1) after edge N.
- Throughput with out_ready held at 1:
  - full words: 2 cycles/word
  - compact-dropped words: 1 cycle/word
- byte_count updates at the same edge that the byte is consumed.

## Test plan
- Reset, LOW_FIRST = 1, out_ready = 1, send 16'hA55A, compact = 0.
  - Bytes 8'h5A then 8'hA5.
  - out_last is 0 then 1.
  - byte_count = 2.
  - in_ready = 1 in the cycle the last byte is taken.
- LOW_FIRST = 0, send 16'h1234 → bytes 8'h12 then 8'h34.
- compact = 1, send 16'h00FF → one byte 8'hFF with out_last = 1, and byte_count increments by 1.
- compact = 1, send 16'h0100 → two bytes (high byte is nonzero), 8'h00 then 8'h01 for LOW_FIRST = 1.
- Stream 16'h0003, 16'h0005, 16'h001B back-to-back with in_valid held and out_ready toggling 1,0,1,0.
  - Every byte is held stable while out_ready = 0.
  - Byte order is 03,00,05,00,1B,00.
  - There are no gaps when out_ready = 1.
  - byte_count = 6.
- Reset behaviour:
  - Assert reset_n low mid-word, while in SECOND with out_ready = 0 → out_valid falls immediately and busy = 0.
  - After release, send 16'h00FF with compact = 0 → bytes FF,00 and byte_count = 2.
- Preload byte_count to 16'hFFFE via 16'hFFFE consumed bytes (or force in sim), then send one full word → byte_count wraps to 16'h0000.
